// File: rtl/result_display.sv
// Seven-segment display stage for the calculator result: latches the 64-bit word,
// pages through it 16 bits at a time and scans four active-low digits.
module result_display #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        result_valid,
    input  logic [63:0] result,
    input  logic [1:0]  size_sel,
    input  logic        page_next,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  page_led
);

    typedef enum logic {IDLE, SHOW} state_t;

    localparam logic [6:0] SEG_DASH = 7'b0111111;

    state_t             state_q, state_d;
    logic [1:0]         page_q, page_d;
    logic [63:0]        word_q, word_d;
    logic [1:0]         size_q, size_d;
    logic [CNT_W-1:0]   presc_q;
    logic [1:0]         digit_q;
    logic [1:0]         top_page;
    logic               sign;
    logic [3:0]         nibble;
    logic [3:0]         an_d;
    logic [6:0]         seg_d;
    logic               dp_d;
    logic               presc_wrap;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    endfunction

    // Top page and sign bit both follow the latched operand size.
    always_comb begin
        case (size_q)
            2'b00:   begin top_page = 2'd0; sign = word_q[15]; end
            2'b01:   begin top_page = 2'd1; sign = word_q[31]; end
            default: begin top_page = 2'd3; sign = word_q[63]; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        word_d  = word_q;
        size_d  = size_q;
        if (result_valid) begin
            state_d = SHOW;
            page_d  = 2'd0;
            word_d  = result;
            size_d  = size_sel;
        end else if (page_next && state_q == SHOW) begin
            page_d = (page_q == top_page) ? 2'd0 : page_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            page_q  <= 2'd0;
            word_q  <= 64'd0;
            size_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            word_q  <= word_d;
            size_q  <= size_d;
        end
    end

    assign presc_wrap = (presc_q == CNT_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            digit_q <= 2'd0;
        end else if (presc_wrap) begin
            presc_q <= '0;
            digit_q <= digit_q + 2'd1;
        end else begin
            presc_q <= presc_q + CNT_W'(1);
        end
    end

    assign nibble = word_q[{page_q, digit_q, 2'b00} +: 4];

    always_comb begin
        an_d  = ~(4'b0001 << digit_q);
        seg_d = SEG_DASH;
        dp_d  = 1'b1;
        if (state_q == SHOW) begin
            seg_d = hex_seg(nibble);
            dp_d  = ~(sign && digit_q == 2'd3 && page_q == top_page);
        end
    end

    // Display drive is registered so the anodes never glitch between slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

    assign page_led = (state_q == SHOW) ? (4'b0001 << page_q) : 4'b0000;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display with SCAN_DIV=4: expected digit frames are
// queued as each result/page is set up and popped while the scan is sampled.
module tb_result_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        result_valid = 1'b0;
    logic [63:0] result = 64'd0;
    logic [1:0]  size_sel = 2'b00;
    logic        page_next = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  page_led;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    result_display #(.SCAN_DIV(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .result_valid(result_valid), .result(result),
        .size_sel(size_sel), .page_next(page_next), .an(an), .seg(seg),
        .dp(dp), .page_led(page_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [63:0] r, input logic [1:0] s, input logic pn);
        @(negedge clk);
        result_valid = 1'b1;
        result = r;
        size_sel = s;
        page_next = pn;
        @(negedge clk);
        result_valid = 1'b0;
        page_next = 1'b0;
    endtask

    task automatic pulse_next();
        @(negedge clk);
        page_next = 1'b1;
        @(negedge clk);
        page_next = 1'b0;
    endtask

    task automatic push_page(input logic [15:0] w, input logic neg);
        for (int d = 0; d < 4; d++)
            exp_q.push_back({~(4'b0001 << d), hex_tab[w[4*d +: 4]], ~(neg && d == 3)});
    endtask

    task automatic push_dash();
        for (int d = 0; d < 4; d++)
            exp_q.push_back({~(4'b0001 << d), 7'b0111111, 1'b1});
    endtask

    // Align to a fresh digit-0 slot, then sample each of the four slots once.
    task automatic scan_check(input string tag);
        int n = 0;
        logic [11:0] e;
        while (an == 4'b1110 && n < 40) begin @(negedge clk); n++; end
        while (an != 4'b1110 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout observed_an=%b expected_an=1110", tag, an);
        end
        for (int d = 0; d < 4; d++) begin
            e = exp_q.pop_front();
            check($sformatf("%s_digit%0d", tag, d), {an, seg, dp}, e);
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_an", {8'd0, an}, 12'h00F);
        check("reset_seg", {5'd0, seg}, 12'h07F);
        check("reset_dp", {11'd0, dp}, 12'h001);
        check("reset_page_led", {8'd0, page_led}, 12'h000);
        rst = 1'b0;

        // Idle scan shows dashes.
        push_dash();
        scan_check("idle");
        check("idle_page_led", {8'd0, page_led}, 12'h000);

        // 16-bit result stays on page 0.
        strobe(64'h0000_0000_0000_12AF, 2'b00, 1'b0);
        check("s16_page_led", {8'd0, page_led}, 12'h001);
        push_page(16'h12AF, 1'b0);
        scan_check("s16");
        pulse_next();
        check("s16_next_page_led", {8'd0, page_led}, 12'h001);
        push_page(16'h12AF, 1'b0);
        scan_check("s16_next");

        // 64-bit result walks all four pages and wraps.
        strobe(64'hDEAD_BEEF_0123_4567, 2'b10, 1'b0);
        check("s64_p0_led", {8'd0, page_led}, 12'h001);
        push_page(16'h4567, 1'b0);
        scan_check("s64_p0");
        pulse_next();
        check("s64_p1_led", {8'd0, page_led}, 12'h002);
        push_page(16'h0123, 1'b0);
        scan_check("s64_p1");
        pulse_next();
        check("s64_p2_led", {8'd0, page_led}, 12'h004);
        pulse_next();
        check("s64_p3_led", {8'd0, page_led}, 12'h008);
        push_page(16'hDEAD, 1'b1);
        scan_check("s64_p3");
        pulse_next();
        check("s64_wrap_led", {8'd0, page_led}, 12'h001);
        push_page(16'h4567, 1'b0);
        scan_check("s64_wrap");

        // 32-bit negative: sign point only on the top page.
        strobe(64'h0000_0000_8000_0001, 2'b01, 1'b0);
        push_page(16'h0001, 1'b0);
        scan_check("s32_p0");
        pulse_next();
        check("s32_p1_led", {8'd0, page_led}, 12'h002);
        push_page(16'h8000, 1'b1);
        scan_check("s32_p1");
        pulse_next();
        check("s32_wrap_led", {8'd0, page_led}, 12'h001);

        // Capture wins over a simultaneous page advance.
        strobe(64'hDEAD_BEEF_0123_4567, 2'b11, 1'b0);
        pulse_next();
        pulse_next();
        check("race_p2_led", {8'd0, page_led}, 12'h004);
        strobe(64'h0000_0000_0000_BEEF, 2'b11, 1'b1);
        check("race_led", {8'd0, page_led}, 12'h001);
        push_page(16'hBEEF, 1'b0);
        scan_check("race");

        // Reset mid-scan, then page_next is ignored while idle.
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_an", {8'd0, an}, 12'h00F);
        check("rst2_seg", {5'd0, seg}, 12'h07F);
        check("rst2_dp", {11'd0, dp}, 12'h001);
        check("rst2_page_led", {8'd0, page_led}, 12'h000);
        rst = 1'b0;
        pulse_next();
        check("idle_next_led", {8'd0, page_led}, 12'h000);
        push_dash();
        scan_check("idle2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
